// File: rtl/hamming_pkg.sv
// Shared SECDED (22,16) definitions: widths, bit-position maps, injection modes
// and the reference encode function also used by checker-side models.
package hamming_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CODE_W = 22;
  localparam int unsigned N_PAR  = 5;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [4:0]        pos_t;

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10,
    INJ_PARITY = 2'b11
  } inj_mode_e;

  localparam pos_t PARITY_POS [N_PAR] = '{5'd0, 5'd1, 5'd3, 5'd7, 5'd15};

  localparam pos_t DATA_POS [DATA_W] = '{
    5'd2,  5'd4,  5'd5,  5'd6,  5'd8,  5'd9,  5'd10, 5'd11,
    5'd12, 5'd13, 5'd14, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20
  };

  function automatic code_t hamming_encode(input data_t d);
    code_t      c;
    logic       p;
    logic [5:0] idx;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      c[DATA_POS[i]] = d[i];
    end
    for (int unsigned k = 0; k < N_PAR; k++) begin
      p = 1'b0;
      for (int unsigned j = 0; j < DATA_W; j++) begin
        idx = {1'b0, DATA_POS[j]} + 6'd1;
        if (idx[k]) p = p ^ d[j];
      end
      c[PARITY_POS[k]] = p;
    end
    c[CODE_W-1] = ^c[CODE_W-2:0];
    return c;
  endfunction

  // Positions beyond the codeword contribute nothing to the mask.
  function automatic code_t onehot_pos(input pos_t p);
    code_t m;
    m = '0;
    if (p < 5'(CODE_W)) m[p] = 1'b1;
    return m;
  endfunction

  function automatic code_t inj_mask(input inj_mode_e mode, input pos_t pa, input pos_t pb);
    code_t m;
    unique case (mode)
      INJ_SINGLE: m = onehot_pos(pa);
      INJ_DOUBLE: m = onehot_pos(pa) ^ onehot_pos(pb);
      INJ_PARITY: m = code_t'(1) << (CODE_W - 1);
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hamming_encoder_if.sv
// Data-in and codeword-out valid/ready handshakes of the Hamming encoder.
interface hamming_encoder_if;
  import hamming_pkg::*;

  logic  in_valid;
  logic  in_ready;
  data_t in_data;
  logic  out_valid;
  logic  out_ready;
  code_t out_code;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code
  );
endinterface

// File: rtl/hamming_skid_fifo.sv
// Two-entry codeword queue with registered count; head entry is always visible.
module hamming_skid_fifo
  import hamming_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  code_t      push_data,
  input  logic       pop,
  output code_t      head,
  output logic [1:0] count
);

  code_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_encoder.sv
// Streaming SECDED encoder: encodes accepted words, optionally corrupts one
// armed codeword, and queues results in a two-entry output FIFO.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  hamming_encoder_if.slave    bus,
  input  logic                inj_arm,
  input  logic [1:0]          inj_mode,
  input  logic [4:0]          inj_pos_a,
  input  logic [4:0]          inj_pos_b,
  output logic                inj_pending,
  output logic [15:0]         word_count
);

  logic [1:0] count;
  logic       accept;
  logic       pop;
  code_t      enc_code;
  code_t      push_code;
  inj_mode_e  mode_q;
  pos_t       pos_a_q;
  pos_t       pos_b_q;

  assign bus.in_ready  = rst_n && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    enc_code  = hamming_encode(bus.in_data);
    push_code = enc_code;
    if (inj_pending) push_code = enc_code ^ inj_mask(mode_q, pos_a_q, pos_b_q);
  end

  // Pending is sampled before the arm takes effect, so a word accepted in the
  // arm cycle itself stays clean and the corruption lands on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pending <= 1'b0;
      mode_q      <= INJ_NONE;
      pos_a_q     <= '0;
      pos_b_q     <= '0;
    end else if (inj_pending) begin
      if (accept) inj_pending <= 1'b0;
    end else if (inj_arm) begin
      inj_pending <= 1'b1;
      mode_q      <= inj_mode_e'(inj_mode);
      pos_a_q     <= inj_pos_a;
      pos_b_q     <= inj_pos_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      word_count <= '0;
    else if (accept) word_count <= word_count + 16'd1;
  end

  hamming_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_code),
    .pop       (pop),
    .head      (bus.out_code),
    .count     (count)
  );

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench for hamming_encoder: directed vectors plus randomized
// traffic against a queue-based reference model.
module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inj_arm = 1'b0;
  logic [1:0]  inj_mode = 2'b00;
  logic [4:0]  inj_pos_a = '0;
  logic [4:0]  inj_pos_b = '0;
  logic        inj_pending;
  logic [15:0] word_count;

  hamming_encoder_if bus ();

  hamming_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .inj_arm     (inj_arm),
    .inj_mode    (inj_mode),
    .inj_pos_a   (inj_pos_a),
    .inj_pos_b   (inj_pos_b),
    .inj_pending (inj_pending),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [21:0] m_q [$];
  logic        m_pending;
  logic [1:0]  m_mode;
  logic [4:0]  m_pa;
  logic [4:0]  m_pb;
  logic [15:0] m_wc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder from first principles: data fills the non-power-of-two
  // 1-based positions in order; parity p_k covers positions with bit k set.
  function automatic logic [21:0] ref_encode(input logic [15:0] d);
    logic [21:0] c;
    int          n;
    c = '0;
    n = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ c[pos-1];
      c[(1 << k) - 1] = p;
    end
    c[21] = ^c[20:0];
    return c;
  endfunction

  function automatic logic [21:0] ref_mask(input logic [1:0] mode, input logic [4:0] pa, input logic [4:0] pb);
    logic [21:0] m;
    m = '0;
    if (mode == 2'b01) begin
      if (pa < 22) m[pa] = 1'b1;
    end else if (mode == 2'b10) begin
      if (pa < 22) m[pa] = ~m[pa];
      if (pb < 22) m[pb] = ~m[pb];
    end else if (mode == 2'b11) begin
      m[21] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_pending = 1'b0;
    m_mode = 2'b00;
    m_pa = '0;
    m_pb = '0;
    m_wc = '0;
  endtask

  task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                      input logic arm, input logic [1:0] mode,
                      input logic [4:0] pa, input logic [4:0] pb);
    logic        acc, pop, old_pend;
    logic [21:0] code;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    inj_arm   = arm;
    inj_mode  = mode;
    inj_pos_a = pa;
    inj_pos_b = pb;
    @(negedge clk);
    check_eq("in_ready", 32'(bus.in_ready), 32'(m_q.size() != 2));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("out_code", 32'(bus.out_code), 32'(m_q[0]));
    check_eq("inj_pending", 32'(inj_pending), 32'(m_pending));
    check_eq("word_count", 32'(word_count), 32'(m_wc));
    acc  = iv && (m_q.size() < 2);
    pop  = ordy && (m_q.size() > 0);
    code = ref_encode(d) ^ (m_pending ? ref_mask(m_mode, m_pa, m_pb) : 22'h0);
    old_pend = m_pending;
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(code);
      m_wc = m_wc + 16'd1;
      if (old_pend) m_pending = 1'b0;
    end
    if (arm && !old_pend) begin
      m_pending = 1'b1;
      m_mode = mode;
      m_pa = pa;
      m_pb = pb;
    end
    inj_arm = 1'b0;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0, ordy, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic send(input logic [15:0] d, input logic ordy);
    step(1'b1, d, ordy, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic arm(input logic [1:0] mode, input logic [4:0] pa, input logic [4:0] pb);
    step(1'b0, 16'h0, 1'b1, 1'b1, mode, pa, pb);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_code", 32'(bus.out_code), 32'd0);
    check_eq("rst_inj_pending", 32'(inj_pending), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    #2;
    apply_reset();

    // Back-to-back with out_ready high.
    send(16'h0001, 1'b1);
    check_eq("tp_code_0001", 32'(bus.out_code), 32'h200007);
    send(16'hFFFF, 1'b1);
    check_eq("tp_code_ffff", 32'(bus.out_code), 32'h1FFFFE);
    send(16'h0000, 1'b1);
    check_eq("tp_code_0000", 32'(bus.out_code), 32'h000000);
    check_eq("tp_word_count3", 32'(word_count), 32'd3);
    idle(1'b1);

    // Stall: only two of three offered words accepted, head held.
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("stall_head", 32'(bus.out_code), 32'h200007);
    idle(1'b0);
    check_eq("stall_head_hold", 32'(bus.out_code), 32'h200007);
    idle(1'b1);
    check_eq("drain_second", 32'(bus.out_code), 32'h1FFFFE);
    idle(1'b1);
    idle(1'b1);

    // Single flip at bit 2, then a clean word.
    arm(2'b01, 5'd2, 5'd0);
    send(16'h0000, 1'b1);
    check_eq("inj_single_code", 32'(bus.out_code), 32'h000004);
    check_eq("inj_single_clear", 32'(inj_pending), 32'd0);
    send(16'h0000, 1'b1);
    check_eq("inj_after_clean", 32'(bus.out_code), 32'h000000);

    // Double flip on the same bit cancels.
    arm(2'b10, 5'd5, 5'd5);
    send(16'h0000, 1'b1);
    check_eq("inj_double_same", 32'(bus.out_code), 32'h000000);

    // Overall-parity flip; second arm while pending is ignored.
    arm(2'b11, 5'd0, 5'd0);
    step(1'b0, 16'h0, 1'b1, 1'b1, 2'b01, 5'd0, 5'd0);
    send(16'h0000, 1'b1);
    check_eq("inj_parity_code", 32'(bus.out_code), 32'h200000);
    send(16'h0000, 1'b1);
    check_eq("inj_rearm_ignored", 32'(bus.out_code), 32'h000000);
    idle(1'b1);

    // Word accepted in the arm cycle stays clean.
    step(1'b1, 16'h0001, 1'b1, 1'b1, 2'b01, 5'd0, 5'd0);
    check_eq("arm_cycle_clean", 32'(bus.out_code), 32'h200007);
    send(16'h0001, 1'b1);
    check_eq("arm_next_dirty", 32'(bus.out_code), 32'h200006);

    // Mid-stream reset with full queue and pending injection.
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    arm(2'b01, 5'd7, 5'd0);
    idle(1'b0);
    apply_reset();
    send(16'hA5A5, 1'b1);

    // Randomized traffic.
    for (int unsigned n = 0; n < 800; n++) begin
      logic        iv, ordy, a;
      logic [1:0]  md;
      logic [4:0]  pa, pb;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      a    = ($urandom_range(0, 9) == 0);
      md   = 2'($urandom_range(0, 3));
      pa   = 5'($urandom_range(0, 31));
      pb   = ($urandom_range(0, 3) == 0) ? pa : 5'($urandom_range(0, 31));
      step(iv, 16'($urandom), ordy, a, md, pa, pb);
      if (n == 400) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
